// File: rtl/fetch_responder_if.sv
//------------------------------------------------------------------------------
// Module : fetch_responder_if
// Brief  : Fetch request/response handshake bundle between PC stage and memory.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr
    );
endinterface

`default_nettype wire

// File: rtl/fetch_responder.sv
//------------------------------------------------------------------------------
// Module : fetch_responder
// Brief  : Instruction memory responder with programmable wait states.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  wire                 CLK,
    input  wire                 areset,
    fetch_responder_if.slave    bus,
    input  wire                 load_en,
    input  wire  [ADDR_W-1:0]   load_addr,
    input  wire  [DATA_W-1:0]   load_data
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("fetch_responder: WAIT_STATES must be in 0..15");
    end

    localparam int         C_DEPTH = 1 << ADDR_W;
    localparam logic [3:0] C_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_mem [C_DEPTH];
    logic              w_accept;

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_addr  = r_rsp_addr;
    assign w_accept      = bus.req_valid && (r_state == S_IDLE);

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= C_WAIT;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read captured at the accept edge, so a same-edge load leaves the old word in flight.
    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
        end else if (w_accept) begin
            r_rsp_data <= r_mem[bus.req_addr];
            r_rsp_addr <= bus.req_addr;
        end
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

endmodule

`default_nettype wire
